// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: run-time pattern/length/mode/target,
// armed by start, stopped by abort or when the match target is reached.
module seq_detect_ctrl #(
    parameter int W  = 8,
    parameter int CW = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in,
    input  logic          cfg_we,
    input  logic [W-1:0]  cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          start,
    input  logic          abort,
    output logic          out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-2:0]  hist_q, hist_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  pattern_q, pattern_d;
    logic [LW-1:0] len_q, len_d;
    logic          overlap_q, overlap_d;
    logic [CW-1:0] target_q, target_d;
    logic          busy_q, done_q;

    logic [W-1:0]  win;
    logic [W-1:0]  mask;
    logic          hit;
    logic [CW-1:0] cnt_inc;

    // Only the newest W-1 bits need storing; the current input completes the window.
    assign win     = {hist_q, in};
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
    end

    // len_q is never 0 while ARMED, so len_q-1 cannot underflow when it matters.
    assign hit = (state_q == ARMED) &&
                 (fill_q >= (len_q - LW'(1))) &&
                 ((win & mask) == (pattern_q & mask));

    assign out       = hit;
    assign busy      = busy_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;

        case (state_q)
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    hist_d = win[W-2:0];
                    fill_d = (fill_q == LW'(W)) ? fill_q : fill_q + LW'(1);
                    if (hit) begin
                        cnt_d = cnt_inc;
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                // IDLE and DONE accept configuration and (re-)arm identically.
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = (cfg_len > LW'(W)) ? LW'(W) : cfg_len;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (start && (len_q != '0)) begin
                    state_d = ARMED;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            busy_q    <= (state_d == ARMED);
            done_q    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; a second CW=2 instance covers counter wrap.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       din = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dout, busy, done;
    logic [7:0] match_cnt;

    logic       w_in = 1'b0;
    logic       w_we = 1'b0;
    logic       w_start = 1'b0;
    logic       w_out, w_busy, w_done;
    logic [1:0] w_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.W(8), .CW(8)) u_dut (
        .clk(clk), .clr(clr), .in(din), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .abort(abort), .out(dout), .busy(busy), .done(done),
        .match_cnt(match_cnt)
    );

    seq_detect_ctrl #(.W(8), .CW(2)) u_wrap (
        .clk(clk), .clr(clr), .in(w_in), .cfg_we(w_we), .cfg_pattern(8'h01),
        .cfg_len(4'd1), .cfg_overlap(1'b1), .cfg_target(2'd0),
        .start(w_start), .abort(1'b0), .out(w_out), .busy(w_busy), .done(w_done),
        .match_cnt(w_cnt)
    );

    // All stimulus tasks begin and end on a falling edge.
    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        din = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nonoverlap();
        logic [7:0] bits, exp;
        bits = 8'b01010010;
        exp  = 8'b00100001;
        cfg(8'h02, 4'd3, 1'b0, 8'd0);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nonovl_busy got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) begin
            din = bits[7-i];
            #1;
            checks++;
            if (dout !== exp[7-i]) begin
                errors++; $display("FAIL nonovl_bit%0d out=%b exp=%b", i + 1, dout, exp[7-i]);
            end
            @(negedge clk);
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL nonovl_cnt got=%0d exp=2", match_cnt); end
        pulse_abort();
    endtask

    task automatic test_overlap();
        logic [7:0] bits, exp;
        bits = 8'b11111101;
        exp  = 8'b00011100;
        cfg(8'h0F, 4'd4, 1'b1, 8'd0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            din = bits[7-i];
            #1;
            checks++;
            if (dout !== exp[7-i]) begin
                errors++; $display("FAIL ovl_bit%0d out=%b exp=%b", i + 1, dout, exp[7-i]);
            end
            @(negedge clk);
        end
        checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL ovl_cnt got=%0d exp=3", match_cnt); end
        pulse_abort();
    endtask

    task automatic test_target();
        logic [5:0] exp;
        exp = 6'b000110;
        cfg(8'h0F, 4'd4, 1'b1, 8'd2);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            din = 1'b1;
            #1;
            checks++;
            if (dout !== exp[5-i]) begin
                errors++; $display("FAIL target_bit%0d out=%b exp=%b", i + 1, dout, exp[5-i]);
            end
            if (i == 4) begin
                @(negedge clk);
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL target_done got=%b exp=1", done); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL target_busy got=%b exp=0", busy); end
            end else begin
                @(negedge clk);
            end
        end
        din = 1'b0;
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL target_cnt got=%0d exp=2", match_cnt); end
    endtask

    task automatic test_abort_rearm();
        logic [3:0] exp;
        exp = 4'b0001;
        // Reconfigure and re-arm straight from DONE.
        cfg(8'h0F, 4'd4, 1'b1, 8'd0);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            @(negedge clk);
        end
        pulse_abort();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            din = 1'b1;
            #1;
            checks++;
            if (dout !== exp[3-i]) begin
                errors++; $display("FAIL rearm_bit%0d out=%b exp=%b", i + 1, dout, exp[3-i]);
            end
            @(negedge clk);
        end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL rearm_cnt got=%0d exp=1", match_cnt); end
        pulse_abort();
    endtask

    task automatic test_boundary();
        logic [3:0] exp4;
        logic [7:0] exp8;
        logic [2:0] exp3;
        exp4 = 4'b0001;
        exp8 = 8'b00000001;
        exp3 = 3'b011;

        // A config write while ARMED must not take effect.
        cfg(8'h0F, 4'd4, 1'b1, 8'd0);
        pulse_start();
        din = 1'b0;
        cfg(8'h03, 4'd2, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) begin
            din = 1'b1;
            #1;
            checks++;
            if (dout !== exp4[3-i]) begin
                errors++; $display("FAIL armed_cfg_bit%0d out=%b exp=%b", i + 1, dout, exp4[3-i]);
            end
            @(negedge clk);
        end
        pulse_abort();

        // Oversized length clamps to W.
        cfg(8'hFF, 4'd15, 1'b1, 8'd0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            din = 1'b1;
            #1;
            checks++;
            if (dout !== exp8[7-i]) begin
                errors++; $display("FAIL clamp_bit%0d out=%b exp=%b", i + 1, dout, exp8[7-i]);
            end
            @(negedge clk);
        end
        pulse_abort();

        cfg(8'h01, 4'd0, 1'b0, 8'd0);
        pulse_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got=%b exp=0", busy); end

        cfg(8'h03, 4'd2, 1'b1, 8'd0);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_both_busy got=%b exp=1", busy); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL both_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL both_done got=%b exp=0", done); end

        pulse_start();
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            #1;
            checks++;
            if (dout !== exp3[2-i]) begin
                errors++; $display("FAIL preclr_bit%0d out=%b exp=%b", i + 1, dout, exp3[2-i]);
            end
            @(negedge clk);
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL preclr_cnt got=%0d exp=2", match_cnt); end
        din = 1'b1;
        #1;
        checks++; if (dout !== 1'b1) begin errors++; $display("FAIL preclr_out got=%b exp=1", dout); end
        clr = 1'b1;
        #1;
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL clr_out got=%b exp=0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done got=%b exp=0", done); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got=%0d exp=0", match_cnt); end
        @(negedge clk);
        clr = 1'b0;
        din = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL postclr_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        w_we = 1'b1;
        @(negedge clk);
        w_we = 1'b0;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_in = 1'b1;
            #1;
            checks++;
            if (w_out !== 1'b1) begin
                errors++; $display("FAIL wrap_bit%0d out=%b exp=1", i + 1, w_out);
            end
            @(negedge clk);
        end
        w_in = 1'b0;
        checks++; if (w_cnt !== 2'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", w_cnt); end
        checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got=%b exp=1", w_busy); end
    endtask

    initial begin
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_target();
        test_abort_rearm();
        test_boundary();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
